// File: rtl/tpu_axi_pkg.sv
// Shared encodings for the TPU AXI write path: burst/response codes, the
// burst-controller state enum, and a byte-lane log2 helper.
package tpu_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic int lane_log2(input int lanes);
        int r;
        r = 0;
        for (int i = 0; i < 30; i++) begin
            if ((32'sd1 <<< i) < lanes) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_wr_burst_ctrl_if.sv
// Signal bundle between the AXI write front end, axi_wr_burst_ctrl, the SRAM
// write port and the B channel.
interface axi_wr_burst_ctrl_if #(
    parameter int AWADDR_WIDTH = 11,
    parameter int AWID_WIDTH   = 8,
    parameter int WDATA_WIDTH  = 32,
    parameter int WSTRB_WIDTH  = 4
);
    import tpu_axi_pkg::*;

    localparam int SRAM_AW = AWADDR_WIDTH - lane_log2(WSTRB_WIDTH);

    logic                    burst_start;
    logic [AWID_WIDTH-1:0]   burst_id;
    logic [AWADDR_WIDTH-1:0] burst_addr;
    logic [1:0]              burst_type;
    logic [2:0]              burst_size;
    logic [7:0]              burst_len;
    logic                    beat_vld;
    logic [WDATA_WIDTH-1:0]  beat_data;
    logic [WSTRB_WIDTH-1:0]  beat_strb;
    logic                    beat_last;
    logic                    ctrl_busy;
    logic                    beat_done;
    logic                    sram_we;
    logic [SRAM_AW-1:0]      sram_addr;
    logic [WDATA_WIDTH-1:0]  sram_wdata;
    logic [WSTRB_WIDTH-1:0]  sram_wstrb;
    logic [AWID_WIDTH-1:0]   BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    modport master (
        output burst_start, burst_id, burst_addr, burst_type, burst_size, burst_len,
        output beat_vld, beat_data, beat_strb, beat_last, BREADY,
        input  ctrl_busy, beat_done, sram_we, sram_addr, sram_wdata, sram_wstrb,
        input  BID, BRESP, BVALID
    );

    modport slave (
        input  burst_start, burst_id, burst_addr, burst_type, burst_size, burst_len,
        input  beat_vld, beat_data, beat_strb, beat_last, BREADY,
        output ctrl_busy, beat_done, sram_we, sram_addr, sram_wdata, sram_wstrb,
        output BID, BRESP, BVALID
    );

endinterface

// File: rtl/axi_wr_burst_ctrl_addr_gen.sv
// axi_burst_addr_gen: combinational next beat address for FIXED/INCR/WRAP.
// The WRAP path (and its len input) exists only when AXI_WR_WRAP_EN is defined.
module axi_burst_addr_gen
    import tpu_axi_pkg::*;
#(
    parameter int AWADDR_WIDTH = 11
) (
    input  logic [AWADDR_WIDTH-1:0] addr,
    input  logic [1:0]              btype,
    input  logic [2:0]              size,
`ifdef AXI_WR_WRAP_EN
    input  logic [7:0]              len,
`endif
    output logic [AWADDR_WIDTH-1:0] next_addr
);
    localparam logic [AWADDR_WIDTH-1:0] ONE = {{(AWADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [AWADDR_WIDTH-1:0] incr_s;
`ifdef AXI_WR_WRAP_EN
    logic [AWADDR_WIDTH-1:0] mask_s;
    logic [AWADDR_WIDTH-1:0] wrap_s;
`endif

    // Next address per burst type; the wrap window is (len+1) beats, aligned down.
    always_comb begin
        incr_s = addr + (ONE << size);
`ifdef AXI_WR_WRAP_EN
        mask_s = ((AWADDR_WIDTH'(len) + ONE) << size) - ONE;
        wrap_s = (addr & ~mask_s) | (incr_s & mask_s);
`endif
        case (btype)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_s;
`ifdef AXI_WR_WRAP_EN
            BURST_WRAP:  next_addr = wrap_s;
`endif
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// AXI write burst sequencer: per-beat SRAM addressing, WLAST framing check, B response.
// Build option AXI_WR_WRAP_EN enables WRAP bursts; without it WRAP is drained with SLVERR.
module axi_wr_burst_ctrl
    import tpu_axi_pkg::*;
#(
    parameter int AWADDR_WIDTH = 11,
    parameter int AWID_WIDTH   = 8,
    parameter int WDATA_WIDTH  = 32,
    parameter int WSTRB_WIDTH  = 4
) (
    input logic               clk,
    input logic               rst,
    axi_wr_burst_ctrl_if.slave bus
);
    localparam int LANE_LOG2 = lane_log2(WSTRB_WIDTH);
    localparam int SRAM_AW   = AWADDR_WIDTH - LANE_LOG2;

    state_e                  state_q, state_d;
    logic [AWID_WIDTH-1:0]   id_q, id_d;
    logic [AWADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]              type_q, type_d;
    logic [2:0]              size_q, size_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    attr_err_q, attr_err_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    we_q, we_d;
    logic [SRAM_AW-1:0]      saddr_q, saddr_d;
    logic [WDATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [WSTRB_WIDTH-1:0]  wstrb_q, wstrb_d;
    logic [AWID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    bvalid_q, bvalid_d;

    logic [AWADDR_WIDTH-1:0] next_addr_s;
    logic                    wrap_bad_s;
    logic                    attr_bad_s;
    logic                    last_beat_s;
    logic                    frame_err_s;

    axi_burst_addr_gen #(.AWADDR_WIDTH(AWADDR_WIDTH)) u_addr_gen (
        .addr      (addr_q),
        .btype     (type_q),
        .size      (size_q),
`ifdef AXI_WR_WRAP_EN
        .len       (len_q),
`endif
        .next_addr (next_addr_s)
    );

    // Legality of the attributes presented with burst_start.
    always_comb begin
`ifdef AXI_WR_WRAP_EN
        wrap_bad_s = (bus.burst_type == BURST_WRAP) &&
                     !(bus.burst_len inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
        wrap_bad_s = (bus.burst_type == BURST_WRAP);
`endif
        attr_bad_s = (bus.burst_type == BURST_RSVD) ||
                     (bus.burst_size > 3'(LANE_LOG2)) || wrap_bad_s;
    end

    // Next-state, counter, error flags and output register values.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        type_d     = type_q;
        size_d     = size_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        attr_err_d = attr_err_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        we_d       = 1'b0;
        saddr_d    = saddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        bvalid_d   = bvalid_q;
        last_beat_s = (cnt_q == len_q);
        frame_err_s = (bus.beat_last != last_beat_s);

        case (state_q)
            ST_IDLE: begin
                if (bus.burst_start) begin
                    id_d       = bus.burst_id;
                    addr_d     = bus.burst_addr;
                    type_d     = bus.burst_type;
                    size_d     = bus.burst_size;
                    len_d      = bus.burst_len;
                    cnt_d      = 8'd0;
                    attr_err_d = attr_bad_s;
                    err_d      = attr_bad_s;
                    busy_d     = 1'b1;
                    state_d    = ST_DATA;
                end else begin
                    busy_d     = 1'b0;
                end
            end
            ST_DATA: begin
                if (bus.beat_vld) begin
                    done_d = 1'b1;
                    addr_d = next_addr_s;
                    cnt_d  = cnt_q + 8'd1;
                    err_d  = err_q | frame_err_s;
                    // Framing errors only affect the response; bad attributes also block writes.
                    if (!attr_err_q) begin
                        we_d    = 1'b1;
                        saddr_d = addr_q[AWADDR_WIDTH-1:LANE_LOG2];
                        wdata_d = bus.beat_data;
                        wstrb_d = bus.beat_strb;
                    end else begin
                        we_d    = 1'b0;
                    end
                    if (last_beat_s) begin
                        state_d  = ST_RESP;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = (err_q || frame_err_s) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        state_d  = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (bvalid_q && bus.BREADY) begin
                    bvalid_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_RESP;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                bvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset drops any in-flight burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            type_q     <= 2'd0;
            size_q     <= 3'd0;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            attr_err_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            saddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bid_q      <= '0;
            bresp_q    <= 2'd0;
            bvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            size_q     <= size_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            attr_err_q <= attr_err_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            saddr_q    <= saddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            bvalid_q   <= bvalid_d;
        end
    end

    assign bus.ctrl_busy  = busy_q;
    assign bus.beat_done  = done_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_addr  = saddr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_wstrb = wstrb_q;
    assign bus.BID        = bid_q;
    assign bus.BRESP      = bresp_q;
    assign bus.BVALID     = bvalid_q;

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// Self-checking bench for axi_wr_burst_ctrl; expectations come from a
// burst-level reference model (AXI_WR_WRAP_EN selects WRAP support).
module tb_axi_wr_burst_ctrl;

    localparam int AW  = 11;
    localparam int IDW = 8;
    localparam int DW  = 32;
    localparam int SW  = 4;

`ifdef AXI_WR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axi_wr_burst_ctrl_if #(.AWADDR_WIDTH(AW), .AWID_WIDTH(IDW), .WDATA_WIDTH(DW), .WSTRB_WIDTH(SW)) bus ();

    axi_wr_burst_ctrl #(.AWADDR_WIDTH(AW), .AWID_WIDTH(IDW), .WDATA_WIDTH(DW), .WSTRB_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Monitor: every SRAM write and every beat_done pulse, sampled mid-cycle.
    int unsigned obs_addr[$];
    logic [31:0] obs_data[$];
    logic [3:0]  obs_strb[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (bus.sram_we === 1'b1) begin
            obs_addr.push_back(int'(bus.sram_addr));
            obs_data.push_back(bus.sram_wdata);
            obs_strb.push_back(bus.sram_wstrb);
        end
        if (bus.beat_done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte address of beat i from the AXI burst rules.
    function automatic int unsigned model_byte_addr(int unsigned start, int unsigned bt,
                                                    int unsigned sz, int unsigned len, int unsigned i);
        int unsigned bytes, window, base;
        bytes = 32'd1 << sz;
        if (bt == 0) return start;
        if (bt == 1) return (start + i * bytes) % 2048;
        window = (len + 1) * bytes;
        base   = start - (start % window);
        return base + ((start - base + i * bytes) % window);
    endfunction

    function automatic bit model_attr_err(int unsigned bt, int unsigned sz, int unsigned len);
        if (bt == 3 || sz > 2) return 1'b1;
        if (bt == 2) return !(WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15));
        return 1'b0;
    endfunction

    task automatic run_burst(input string name, input logic [7:0] id, input int unsigned start,
                             input int unsigned bt, input int unsigned sz, input int unsigned len,
                             input int bad_last_idx, input int bready_wait, input bit gaps,
                             input bit seq_data, input bit onehot_strb, input bit poke_start);
        logic [31:0] data_a [256];
        logic [3:0]  strb_a [256];
        int          w0, d0, n_exp;
        bit          attr_err, frame_err;
        logic [1:0]  exp_resp;
        int unsigned exp_word;

        w0 = obs_addr.size();
        d0 = done_cnt;
        attr_err  = model_attr_err(bt, sz, len);
        frame_err = (bad_last_idx >= 0) && (bad_last_idx <= int'(len));
        exp_resp  = (attr_err || frame_err) ? 2'd2 : 2'd0;
        n_exp     = attr_err ? 0 : int'(len) + 1;

        bus.burst_id    = id;
        bus.burst_addr  = start[10:0];
        bus.burst_type  = bt[1:0];
        bus.burst_size  = sz[2:0];
        bus.burst_len   = len[7:0];
        bus.burst_start = 1'b1;
        bus.BREADY      = 1'b0;
        tick();
        bus.burst_start = 1'b0;
        checks++;
        if (bus.ctrl_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, bus.ctrl_busy);
        end

        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            data_a[i] = seq_data ? (32'hA0 + i) : $urandom;
            strb_a[i] = onehot_strb ? 4'(32'd1 << i) : 4'($urandom);
            bus.beat_vld  = 1'b1;
            bus.beat_data = data_a[i];
            bus.beat_strb = strb_a[i];
            bus.beat_last = (i == int'(len)) ^ (i == bad_last_idx);
            if (poke_start && i == 0) begin
                bus.burst_start = 1'b1;
                bus.burst_id    = ~id;
                bus.burst_addr  = 11'h7F0;
                bus.burst_type  = 2'd1;
            end
            if (i == int'(len)) bus.BREADY = (bready_wait == 0);
            tick();
            bus.beat_vld    = 1'b0;
            bus.burst_start = 1'b0;
        end

        checks++;
        if (bus.BVALID !== 1'b1 || bus.BID !== id || bus.BRESP !== exp_resp) begin
            errors++;
            $display("FAIL %s bresp: got valid %b id %h resp %0d want valid 1 id %h resp %0d",
                     name, bus.BVALID, bus.BID, bus.BRESP, id, exp_resp);
        end
        for (int k = 0; k < bready_wait; k++) begin
            tick();
            checks++;
            if (bus.BVALID !== 1'b1 || bus.BID !== id || bus.BRESP !== exp_resp) begin
                errors++;
                $display("FAIL %s b_hold%0d: got valid %b id %h resp %0d want valid 1 id %h resp %0d",
                         name, k, bus.BVALID, bus.BID, bus.BRESP, id, exp_resp);
            end
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        checks++;
        if (bus.BVALID !== 1'b0 || bus.ctrl_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s b_release: got valid %b busy %b want 0 0", name, bus.BVALID, bus.ctrl_busy);
        end

        checks++;
        if (done_cnt - d0 != int'(len) + 1) begin
            errors++;
            $display("FAIL %s beat_done_count: got %0d want %0d", name, done_cnt - d0, len + 1);
        end
        checks++;
        if (obs_addr.size() - w0 != n_exp) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, obs_addr.size() - w0, n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                exp_word = model_byte_addr(start, bt, sz, len, i) >> 2;
                checks++;
                if (obs_addr[w0+i] != exp_word || obs_data[w0+i] !== data_a[i] || obs_strb[w0+i] !== strb_a[i]) begin
                    errors++;
                    $display("FAIL %s write%0d: got addr %0d data %h strb %h want addr %0d data %h strb %h",
                             name, i, obs_addr[w0+i], obs_data[w0+i], obs_strb[w0+i], exp_word, data_a[i], strb_a[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({bus.ctrl_busy, bus.beat_done, bus.sram_we, bus.sram_addr, bus.sram_wdata,
             bus.sram_wstrb, bus.BID, bus.BRESP, bus.BVALID} !== 59'd0) begin
            errors++;
            $display("FAIL reset_values: got busy %b done %b we %b addr %0d bvalid %b want all 0",
                     bus.ctrl_busy, bus.beat_done, bus.sram_we, bus.sram_addr, bus.BVALID);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_beat();
        int w0, d0;
        w0 = obs_addr.size();
        d0 = done_cnt;
        bus.beat_vld  = 1'b1;
        bus.beat_data = 32'hDEAD_BEEF;
        bus.beat_strb = 4'hF;
        bus.beat_last = 1'b1;
        repeat (3) tick();
        bus.beat_vld = 1'b0;
        tick();
        checks++;
        if (done_cnt != d0 || obs_addr.size() != w0 || bus.ctrl_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_beat: got done %0d writes %0d busy %b want 0 0 0",
                     done_cnt - d0, obs_addr.size() - w0, bus.ctrl_busy);
        end
    endtask

    task automatic test_incr();
        run_burst("incr", 8'h5A, 32'h010, 1, 2, 3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run_burst("wrap", 8'h33, 32'h018, 2, 2, 3, -1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fixed();
        run_burst("fixed", 8'h21, 32'h020, 0, 2, 2, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_framing();
        run_burst("early_last", 8'h44, 32'h040, 1, 2, 3, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_burst("missing_last", 8'h45, 32'h080, 1, 2, 3, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_attr_err();
        run_burst("type3", 8'hC3, 32'h100, 3, 2, 1, -1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_burst("size3", 8'hC4, 32'h100, 1, 3, 1, -1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            run_burst("b2b", 8'(8'h10 + n), $urandom_range(0, 2047), $urandom_range(0, 1),
                      $urandom_range(0, 2), $urandom_range(0, 7), -1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int unsigned bt, sz, len;
            int          bad;
            bt = $urandom_range(0, 3);
            sz = $urandom_range(0, 3);
            if (bt == 2) len = (32'd2 << $urandom_range(0, 3)) - 1;
            else         len = $urandom_range(0, 15);
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
            run_burst("random", 8'($urandom), $urandom_range(0, 2047), bt, sz, len, bad,
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_burst();
        bus.burst_id    = 8'h77;
        bus.burst_addr  = 11'h100;
        bus.burst_type  = 2'd1;
        bus.burst_size  = 3'd2;
        bus.burst_len   = 8'd7;
        bus.burst_start = 1'b1;
        tick();
        bus.burst_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.beat_vld  = 1'b1;
            bus.beat_data = $urandom;
            bus.beat_strb = 4'hF;
            bus.beat_last = 1'b0;
            tick();
        end
        bus.beat_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ctrl_busy, bus.beat_done, bus.sram_we, bus.sram_addr, bus.sram_wdata,
             bus.sram_wstrb, bus.BID, bus.BRESP, bus.BVALID} !== 59'd0) begin
            errors++;
            $display("FAIL mid_burst_reset: got busy %b done %b we %b addr %0d want all 0",
                     bus.ctrl_busy, bus.beat_done, bus.sram_we, bus.sram_addr);
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        run_burst("after_reset", 8'h78, 32'h200, 1, 2, 3, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.burst_start = 1'b0;
        bus.burst_id    = 8'h00;
        bus.burst_addr  = 11'h000;
        bus.burst_type  = 2'd0;
        bus.burst_size  = 3'd0;
        bus.burst_len   = 8'd0;
        bus.beat_vld    = 1'b0;
        bus.beat_data   = 32'h0;
        bus.beat_strb   = 4'h0;
        bus.beat_last   = 1'b0;
        bus.BREADY      = 1'b0;

        test_reset();
        test_idle_beat();
        test_incr();
        test_wrap();
        test_fixed();
        test_framing();
        test_attr_err();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
